mmio_responder: RTL and testbench



---
 rtl/mmio_responder.sv | 136 +++++++++++++
 tb/tb_mmio_responder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mmio_responder.sv
// Memory-mapped I/O responder: UART RX/TX byte FIFOs plus cycle and retired-instruction counters.
// Loads return registered data one cycle after the request, like a synchronous RAM read.
module mmio_responder #(
  parameter logic [3:0]  BASE_NIBBLE = 4'h8,
  parameter int unsigned RX_DEPTH    = 4,
  parameter int unsigned TX_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  input  logic        req_rd,
  output logic [31:0] rdata,
  input  logic        inst_retired,
  input  logic [7:0]  rx_in_data,
  input  logic        rx_in_valid,
  output logic        rx_in_ready,
  output logic [7:0]  tx_out_data,
  output logic        tx_out_valid,
  input  logic        tx_out_ready
);

  localparam int unsigned RX_AW = $clog2(RX_DEPTH);
  localparam int unsigned TX_AW = $clog2(TX_DEPTH);
  localparam int unsigned RX_CW = RX_AW + 1;
  localparam int unsigned TX_CW = TX_AW + 1;

  localparam logic [7:0] OFF_STATUS = 8'h00;
  localparam logic [7:0] OFF_RXDATA = 8'h04;
  localparam logic [7:0] OFF_TXDATA = 8'h08;
  localparam logic [7:0] OFF_CYCLE  = 8'h10;
  localparam logic [7:0] OFF_INSTR  = 8'h14;
  localparam logic [7:0] OFF_CNTRST = 8'h18;

  logic [7:0]       rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [RX_CW-1:0] rx_count;
  logic [7:0]       tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [TX_CW-1:0] tx_count;
  logic             tx_ovf;
  logic [31:0]      cycle_cnt;
  logic [31:0]      instret_cnt;

  logic        rx_full, rx_empty, tx_full, tx_empty;
  logic        sel, ld, st;
  logic [7:0]  off;
  logic        rx_push, rx_pop, tx_push, tx_pop, tx_push_req, ovf_set, ovf_clr, cnt_clr;
  logic [31:0] rd_val;

  // Unused address/data bits gathered so lint sees them consumed.
  logic unused_ok;
  assign unused_ok = ^{req_addr[27:8], req_wdata[31:8]};

  assign rx_full  = (rx_count == RX_CW'(RX_DEPTH));
  assign rx_empty = (rx_count == '0);
  assign tx_full  = (tx_count == TX_CW'(TX_DEPTH));
  assign tx_empty = (tx_count == '0);

  assign rx_in_ready  = !rx_full;
  assign tx_out_valid = !tx_empty;
  assign tx_out_data  = tx_mem[tx_rd_ptr];

  assign sel = (req_addr[31:28] == BASE_NIBBLE);
  assign off = req_addr[7:0];
  assign ld  = req_rd & sel;
  assign st  = (|req_wmask) & sel;

  // Full/empty flags are pre-edge, so a same-cycle pop never frees a slot for a push.
  assign rx_push     = rx_in_valid & !rx_full;
  assign rx_pop      = ld & (off == OFF_RXDATA) & !rx_empty;
  assign tx_push_req = st & (off == OFF_TXDATA);
  assign tx_push     = tx_push_req & !tx_full;
  assign ovf_set     = tx_push_req & tx_full;
  assign tx_pop      = !tx_empty & tx_out_ready;
  assign ovf_clr     = ld & (off == OFF_STATUS);
  assign cnt_clr     = st & (off == OFF_CNTRST);

  // Load data mux over pre-edge state.
  always_comb begin
    rd_val = '0;
    if (sel) begin
      case (off)
        OFF_STATUS: rd_val = {29'b0, tx_ovf, !rx_empty, !tx_full};
        OFF_RXDATA: rd_val = rx_empty ? 32'b0 : {24'b0, rx_mem[rx_rd_ptr]};
        OFF_CYCLE:  rd_val = cycle_cnt;
        OFF_INSTR:  rd_val = instret_cnt;
        default:    rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_in_data;
    if (tx_push) tx_mem[tx_wr_ptr] <= req_wdata[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wr_ptr   <= '0;
      rx_rd_ptr   <= '0;
      rx_count    <= '0;
      tx_wr_ptr   <= '0;
      tx_rd_ptr   <= '0;
      tx_count    <= '0;
      tx_ovf      <= 1'b0;
      cycle_cnt   <= '0;
      instret_cnt <= '0;
      rdata       <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
      rx_count <= rx_count + RX_CW'(rx_push) - RX_CW'(rx_pop);

      if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
      tx_count <= tx_count + TX_CW'(tx_push) - TX_CW'(tx_pop);

      // A fresh overflow wins over a same-cycle status-read clear.
      if (ovf_set)      tx_ovf <= 1'b1;
      else if (ovf_clr) tx_ovf <= 1'b0;

      if (cnt_clr) begin
        cycle_cnt   <= '0;
        instret_cnt <= '0;
      end else begin
        cycle_cnt   <= cycle_cnt + 32'd1;
        instret_cnt <= instret_cnt + 32'(inst_retired);
      end

      if (req_rd) rdata <= rd_val;
    end
  end

endmodule

// File: tb/tb_mmio_responder.sv
// Bench for mmio_responder: queue-based reference model checked every cycle,
// plus directed transactions with hand-computed expectations.
module tb_mmio_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wmask = '0;
  logic        req_rd = 1'b0;
  logic [31:0] rdata;
  logic        inst_retired = 1'b0;
  logic [7:0]  rx_in_data = '0;
  logic        rx_in_valid = 1'b0;
  logic        rx_in_ready;
  logic [7:0]  tx_out_data;
  logic        tx_out_valid;
  logic        tx_out_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  mmio_responder #(.BASE_NIBBLE(4'h8), .RX_DEPTH(4), .TX_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask), .req_rd(req_rd),
    .rdata(rdata), .inst_retired(inst_retired),
    .rx_in_data(rx_in_data), .rx_in_valid(rx_in_valid), .rx_in_ready(rx_in_ready),
    .tx_out_data(tx_out_data), .tx_out_valid(tx_out_valid), .tx_out_ready(tx_out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: byte queues, a sticky flag and two counters.
  byte unsigned m_rxq[$];
  byte unsigned m_txq[$];
  bit           m_ovf = 0;
  logic [31:0]  m_cyc = '0;
  logic [31:0]  m_inst = '0;
  logic [31:0]  m_rdata = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rxq.delete();
      m_txq.delete();
      m_ovf = 0;
      m_cyc = '0;
      m_inst = '0;
      m_rdata = '0;
    end else begin
      automatic bit          s     = (req_addr[31:28] == 4'h8);
      automatic logic [7:0]  o     = req_addr[7:0];
      automatic bit          ld    = req_rd && s;
      automatic bit          st    = (req_wmask != 0) && s;
      automatic int          rx_n  = m_rxq.size();
      automatic int          tx_n  = m_txq.size();
      automatic logic [31:0] v     = 0;
      if (s) begin
        if (o == 8'h00) v = {29'b0, m_ovf, rx_n != 0, tx_n < 4};
        else if (o == 8'h04) v = (rx_n != 0) ? {24'b0, m_rxq[0]} : 32'h0;
        else if (o == 8'h10) v = m_cyc;
        else if (o == 8'h14) v = m_inst;
      end
      if (req_rd) m_rdata = v;
      if (ld && o == 8'h04 && rx_n != 0) void'(m_rxq.pop_front());
      if (rx_in_valid && rx_n < 4) m_rxq.push_back(rx_in_data);
      if (tx_n != 0 && tx_out_ready) void'(m_txq.pop_front());
      if (ld && o == 8'h00) m_ovf = 0;
      if (st && o == 8'h08) begin
        if (tx_n < 4) m_txq.push_back(req_wdata[7:0]);
        else m_ovf = 1;
      end
      if (st && o == 8'h18) begin
        m_cyc = 0;
        m_inst = 0;
      end else begin
        m_cyc = m_cyc + 1;
        m_inst = m_inst + 32'(inst_retired);
      end
    end
  end

  // Per-cycle comparison against the model, well after the edge.
  always @(posedge clk) begin
    #2;
    check("model_rdata", rdata, m_rdata);
    check("model_rx_ready", 32'(rx_in_ready), 32'(m_rxq.size() < 4));
    check("model_tx_valid", 32'(tx_out_valid), 32'(m_txq.size() != 0));
    if (m_txq.size() != 0) check("model_tx_data", 32'(tx_out_data), 32'(m_txq[0]));
  end

  task automatic do_read(input logic [31:0] a, input logic [31:0] exp, input string name);
    req_addr = a;
    req_rd = 1'b1;
    @(negedge clk);
    req_rd = 1'b0;
    check(name, rdata, exp);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    req_addr = a;
    req_wdata = d;
    req_wmask = 4'hF;
    @(negedge clk);
    req_wmask = 4'h0;
  endtask

  task automatic rx_push(input logic [7:0] d);
    rx_in_data = d;
    rx_in_valid = 1'b1;
    @(negedge clk);
    rx_in_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] tx_exp [4];
    tx_exp[0] = 8'h55; tx_exp[1] = 8'h66; tx_exp[2] = 8'h77; tx_exp[3] = 8'h88;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state and empty-RX read.
    check("reset_rdata", rdata, 32'h0);
    do_read(32'h8000_0000, 32'h0000_0001, "status_after_reset");
    do_read(32'h8000_0004, 32'h0000_0000, "rx_read_empty");
    do_read(32'h0000_0010, 32'h0000_0000, "unselected_read");

    // Fill RX, overflow offer rejected, drain in order.
    rx_push(8'h41); rx_push(8'h42); rx_push(8'h43); rx_push(8'h44);
    check("rx_ready_full", 32'(rx_in_ready), 32'h0);
    rx_push(8'h45);
    do_read(32'h8000_0004, 32'h41, "rx_pop0");
    do_read(32'h8000_0004, 32'h42, "rx_pop1");
    do_read(32'h8000_0004, 32'h43, "rx_pop2");
    do_read(32'h8000_0004, 32'h44, "rx_pop3");
    do_read(32'h8000_0000, 32'h0000_0001, "status_rx_drained");

    // TX fill with overflow, sticky bit cleared by read.
    tx_out_ready = 1'b0;
    do_write(32'h8000_0008, 32'h55);
    do_write(32'h8000_0008, 32'h66);
    do_write(32'h8000_0008, 32'h77);
    do_write(32'h8000_0008, 32'h88);
    do_write(32'h8000_0008, 32'h99);
    do_read(32'h8000_0000, 32'h0000_0004, "status_tx_ovf");
    do_read(32'h8000_0000, 32'h0000_0000, "status_ovf_cleared");
    tx_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("tx_drain_valid", 32'(tx_out_valid), 32'h1);
      check("tx_drain_data", 32'(tx_out_data), 32'(tx_exp[i]));
      @(negedge clk);
    end
    check("tx_empty_after", 32'(tx_out_valid), 32'h0);

    // Same-cycle RX push and pop with two entries held.
    rx_push(8'h10); rx_push(8'h11);
    rx_in_data = 8'h12;
    rx_in_valid = 1'b1;
    do_read(32'h8000_0004, 32'h10, "rx_simul_pop");
    rx_in_valid = 1'b0;
    do_read(32'h8000_0004, 32'h11, "rx_order1");
    do_read(32'h8000_0004, 32'h12, "rx_order2");
    do_read(32'h8000_0000, 32'h0000_0001, "rx_count_kept");

    // Counter reset beats a same-cycle increment.
    inst_retired = 1'b1;
    @(negedge clk);
    do_write(32'h8000_0018, 32'h1);
    inst_retired = 1'b0;
    do_read(32'h8000_0014, 32'h0, "instret_cleared");
    do_read(32'h8000_0010, 32'h1, "cycle_after_clear");
    inst_retired = 1'b1;
    repeat (3) @(negedge clk);
    inst_retired = 1'b0;
    do_read(32'h8000_0014, 32'h3, "instret_counts");

    // Cycle counter wraps from all-ones.
    force dut.cycle_cnt = 32'hFFFF_FFFF;
    m_cyc = 32'hFFFF_FFFF;
    #1 release dut.cycle_cnt;
    @(negedge clk);
    do_read(32'h8000_0010, 32'h0, "cycle_wrap");

    // Asynchronous reset with TX holding three bytes.
    tx_out_ready = 1'b0;
    do_write(32'h8000_0008, 32'hA1);
    do_write(32'h8000_0008, 32'hA2);
    do_write(32'h8000_0008, 32'hA3);
    rx_push(8'h77);
    check("tx_valid_before_rst", 32'(tx_out_valid), 32'h1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_tx_valid", 32'(tx_out_valid), 32'h0);
    check("async_rx_ready", 32'(rx_in_ready), 32'h1);
    check("async_rdata", rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    do_read(32'h8000_0000, 32'h0000_0001, "status_after_async");
    do_read(32'h8000_0014, 32'h0, "instret_after_async");
    do_read(32'h8000_0010, 32'h2, "cycle_after_async");
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
